wired_rename_scoreboard: RTL and testbench
==========================================

WIRED_RENAME_SCOREBOARD -- requirements
Module: wired_rename_scoreboard

Interface
REQ-001 Parameter ROB_ID_W, default 5, width of ROB entry tag (32-entry ROB).
REQ-002 Parameter ARCH_REGS, default 32, architectural register count; register 0 is hard-wired zero.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 r_valid_i  in  1  rename packet valid.
REQ-006 r_ready_o  out  1  scoreboard accepts packet.
REQ-007 r_mask_i  in  2  per-slot valid within packet.
REQ-008 r_rs_i  in  2x2x5  source arch register ids, [slot][operand].
REQ-009 r_rd_i  in  2x5  destination arch register id per slot.
REQ-010 r_wen_i  in  2  slot writes r_rd_i.
REQ-011 r_rob_id_i  in  2xROB_ID_W  ROB tag allocated per slot.
REQ-012 r_src_busy_o  out  2x2  source has in-flight producer.
REQ-013 r_src_tag_o  out  2x2xROB_ID_W  producer ROB tag, valid when busy.
REQ-014 c_valid_i  in  2  commit slot valid (same slots driving ARF write ports).
REQ-015 c_wen_i, c_rd_i, c_rob_id_i  in  2, 2x5, 2xROB_ID_W  committed write info.
REQ-016 flush_i  in  1  pipeline flush (mispredict/exception).
REQ-017 busy_cnt_o  out  6  registered count of busy registers.

Function
REQ-018 State per register: busy bit + ROB tag; register 0 never busy.
REQ-019 Packet fires on r_valid_i & r_ready_o; r_ready_o = (state==RUN) & ~flush_i.
REQ-020 Lookup combinational from current table; slot1 operand matching slot0 r_rd_i (slot0 masked, wen, rd!=0) returns busy=1, tag=slot0 r_rob_id_i (intra-packet bypass).
REQ-021 Lookup of a register cleared by a same-cycle commit (tag match) returns busy=0; ARF provides write-first read.
REQ-022 On fire, each masked slot with wen and rd!=0 sets busy, tag=r_rob_id_i; visible next cycle.
REQ-023 Both slots same rd: slot1 tag wins.
REQ-024 Commit clears busy only if stored tag equals c_rob_id_i; mismatch (younger rename) leaves entry.
REQ-025 Same-cycle rename set and commit clear of same register: set wins.
REQ-026 State machine RUN/FLUSH: flush_i in RUN -> FLUSH next cycle; FLUSH clears all busy bits and returns to RUN next cycle; r_ready_o=0 during flush_i cycle and FLUSH cycle.
REQ-027 flush_i during FLUSH keeps FLUSH one more cycle.
REQ-028 Commits during flush_i/FLUSH are ignored for table (table cleared anyway).
REQ-029 busy_cnt_o = popcount of table after each update, range 0..31, never wraps.
REQ-030 Outputs r_src_* undefined-safe (drive 0 tag) when source not busy.

Reset
REQ-031 rst: state=RUN, all busy bits 0, tags 0, busy_cnt_o=0; r_ready_o=1 cycle after rst deasserts.
REQ-032 rst mid-flush or mid-packet aborts; no pending update survives.

Structure
REQ-033 arch_rid_t, rob_id_t, ROB_ID_W and scoreboard state enum in shared wired0 package.
REQ-034 One sub-module natural: wired_popcount (32-bit -> 6-bit) for busy_cnt_o.
REQ-035 Table as flops (32x(1+ROB_ID_W)); no SRAM.

Verification
REQ-036 Rename slot0 rd=5 tag=3; next cycle lookup rs=5 -> busy=1 tag=3; busy_cnt_o=1.
REQ-037 Same packet slot0 rd=7 tag=4, slot1 rs=7 -> slot1 busy=1 tag=4; slot0 rs=7 -> busy=0.
REQ-038 rd=9 tag=2, then rd=9 tag=6, commit rd=9 tag=2 -> still busy tag=6; commit tag=6 -> busy=0.
REQ-039 Rename rd=0 wen=1 -> never busy, busy_cnt_o unchanged.
REQ-040 10 regs busy, assert flush_i -> r_ready_o=0 two cycles, then all busy=0, busy_cnt_o=0, r_ready_o=1.
REQ-041 Same cycle rename rd=12 tag=8 and commit rd=12 tag=1 (stored 1) -> busy=1 tag=8.

Source files
------------

// File: rtl/wired0_pkg.sv
// Shared types and constants for the wired rename scoreboard.
// Ports: none (package only).
// Holds the arch register id type, ROB tag type, table sizes and the scoreboard FSM encoding.
package wired0_pkg;

    localparam int ROB_ID_W  = 5;
    localparam int ARCH_REGS = 32;
    localparam int AREG_W    = 5;
    localparam int CNT_W     = 6;

    typedef logic [AREG_W-1:0]   arch_rid_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_FLUSH = 1'b1
    } sb_state_e;

    // A slot only touches the table when it is valid, writes, and targets a real register.
    function automatic logic writes_reg(input logic vld, input logic wen, input arch_rid_t rd);
        return vld & wen & (rd != '0);
    endfunction

endpackage

// File: rtl/wired_rename_scoreboard_popcount.sv
// Population count of the busy vector, feeding the registered busy counter.
// Ports: vec_i (busy bits), cnt_o (number of set bits), purely combinational.
// Latency: zero cycles; no backpressure.
module wired_popcount
    import wired0_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]     vec_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) begin
            cnt_o = cnt_o + CNT_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/wired_rename_scoreboard.sv
// Rename-stage busy/tag scoreboard: tracks which arch registers await an in-flight ROB producer.
// Ports: rename packet (r_*), commit slots (c_*), flush_i, busy_cnt_o; lookups are combinational.
// Backpressure: r_ready_o drops for the flush_i cycle and every FLUSH cycle; commits are never stalled.
module wired_rename_scoreboard
    import wired0_pkg::AREG_W;
    import wired0_pkg::CNT_W;
    import wired0_pkg::sb_state_e;
    import wired0_pkg::SB_RUN;
    import wired0_pkg::SB_FLUSH;
    import wired0_pkg::writes_reg;
#(
    parameter int ROB_ID_W  = wired0_pkg::ROB_ID_W,
    parameter int ARCH_REGS = wired0_pkg::ARCH_REGS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               r_valid_i,
    output logic                               r_ready_o,
    input  logic [1:0]                         r_mask_i,
    input  logic [1:0][1:0][AREG_W-1:0]        r_rs_i,
    input  logic [1:0][AREG_W-1:0]             r_rd_i,
    input  logic [1:0]                         r_wen_i,
    input  logic [1:0][ROB_ID_W-1:0]           r_rob_id_i,
    output logic [1:0][1:0]                    r_src_busy_o,
    output logic [1:0][1:0][ROB_ID_W-1:0]      r_src_tag_o,
    input  logic [1:0]                         c_valid_i,
    input  logic [1:0]                         c_wen_i,
    input  logic [1:0][AREG_W-1:0]             c_rd_i,
    input  logic [1:0][ROB_ID_W-1:0]           c_rob_id_i,
    input  logic                               flush_i,
    output logic [CNT_W-1:0]                   busy_cnt_o
);

    sb_state_e             state_q, state_d;
    logic [ARCH_REGS-1:0]  busy_q, busy_d;
    logic [ROB_ID_W-1:0]   tag_q [ARCH_REGS];
    logic [ROB_ID_W-1:0]   tag_d [ARCH_REGS];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ARCH_REGS-1:0]  clr_vec;
    logic                  fire;
    logic                  commit_en;

    assign r_ready_o  = (state_q == SB_RUN) & ~flush_i;
    assign fire       = r_valid_i & r_ready_o;
    // Commits only matter while running; a flush wipes the table regardless.
    assign commit_en  = r_ready_o;
    assign busy_cnt_o = cnt_q;

    // Commit clears: only when the stored tag is still the committing producer,
    // otherwise a younger rename owns the entry.
    always_comb begin
        clr_vec = '0;
        for (int c = 0; c < 2; c++) begin
            if (commit_en && writes_reg(c_valid_i[c], c_wen_i[c], c_rd_i[c]) &&
                (tag_q[c_rd_i[c]] == c_rob_id_i[c])) begin
                clr_vec[c_rd_i[c]] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_RUN:   if (flush_i) state_d = SB_FLUSH;
            SB_FLUSH: state_d = flush_i ? SB_FLUSH : SB_RUN;
            default:  state_d = SB_RUN;
        endcase
    end

    // Clears applied before sets so a same-cycle rename of the register wins;
    // slot1 is applied after slot0 so it wins on a shared rd.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        if (state_q == SB_FLUSH) begin
            busy_d = '0;
        end else begin
            busy_d = busy_q & ~clr_vec;
            if (fire) begin
                for (int s = 0; s < 2; s++) begin
                    if (writes_reg(r_mask_i[s], r_wen_i[s], r_rd_i[s])) begin
                        busy_d[r_rd_i[s]] = 1'b1;
                        tag_d[r_rd_i[s]]  = r_rob_id_i[s];
                    end
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    // Source lookup: write-first against same-cycle commits, then the slot0->slot1 bypass.
    // Tag is forced to zero whenever the source is not busy.
    always_comb begin
        r_src_busy_o = '0;
        r_src_tag_o  = '0;
        for (int s = 0; s < 2; s++) begin
            for (int o = 0; o < 2; o++) begin
                if ((r_rs_i[s][o] != '0) && busy_q[r_rs_i[s][o]] && !clr_vec[r_rs_i[s][o]]) begin
                    r_src_busy_o[s][o] = 1'b1;
                    r_src_tag_o[s][o]  = tag_q[r_rs_i[s][o]];
                end
                if ((s == 1) && writes_reg(r_mask_i[0], r_wen_i[0], r_rd_i[0]) &&
                    (r_rd_i[0] == r_rs_i[s][o])) begin
                    r_src_busy_o[s][o] = 1'b1;
                    r_src_tag_o[s][o]  = r_rob_id_i[0];
                end
            end
        end
    end

    wired_popcount #(
        .W (ARCH_REGS)
    ) u_popcount (
        .vec_i (busy_d),
        .cnt_o (cnt_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SB_RUN;
            busy_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < ARCH_REGS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < ARCH_REGS; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wired_rename_scoreboard.sv
// Directed bench with an expectation queue drained by a monitor on the falling edge.
// Ports: none (top-level bench).
// Stimulus is applied 1ns after each rising edge; expected values are hand-derived.
module tb_wired_rename_scoreboard;

    localparam int RW = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    r_valid_i;
    logic                    r_ready_o;
    logic [1:0]              r_mask_i;
    logic [1:0][1:0][4:0]    r_rs_i;
    logic [1:0][4:0]         r_rd_i;
    logic [1:0]              r_wen_i;
    logic [1:0][RW-1:0]      r_rob_id_i;
    logic [1:0][1:0]         r_src_busy_o;
    logic [1:0][1:0][RW-1:0] r_src_tag_o;
    logic [1:0]              c_valid_i;
    logic [1:0]              c_wen_i;
    logic [1:0][4:0]         c_rd_i;
    logic [1:0][RW-1:0]      c_rob_id_i;
    logic                    flush_i;
    logic [5:0]              busy_cnt_o;

    always #5 clk = ~clk;

    wired_rename_scoreboard #(.ROB_ID_W(RW), .ARCH_REGS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .r_valid_i    (r_valid_i),
        .r_ready_o    (r_ready_o),
        .r_mask_i     (r_mask_i),
        .r_rs_i       (r_rs_i),
        .r_rd_i       (r_rd_i),
        .r_wen_i      (r_wen_i),
        .r_rob_id_i   (r_rob_id_i),
        .r_src_busy_o (r_src_busy_o),
        .r_src_tag_o  (r_src_tag_o),
        .c_valid_i    (c_valid_i),
        .c_wen_i      (c_wen_i),
        .c_rd_i       (c_rd_i),
        .c_rob_id_i   (c_rob_id_i),
        .flush_i      (flush_i),
        .busy_cnt_o   (busy_cnt_o)
    );

    typedef struct {
        bit                 chk_src;
        logic [3:0]         busy;
        logic [3:0][RW-1:0] tag;
        logic [5:0]         cnt;
        logic               rdy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic  obs_req = 1'b0;

    task automatic clr_in();
        r_valid_i  = 1'b0;
        r_mask_i   = '0;
        r_rs_i     = '0;
        r_rd_i     = '0;
        r_wen_i    = '0;
        r_rob_id_i = '0;
        c_valid_i  = '0;
        c_wen_i    = '0;
        c_rd_i     = '0;
        c_rob_id_i = '0;
        flush_i    = 1'b0;
    endtask

    task automatic ren(input int s, input int rd, input int tag);
        r_valid_i     = 1'b1;
        r_mask_i[s]   = 1'b1;
        r_wen_i[s]    = 1'b1;
        r_rd_i[s]     = rd[4:0];
        r_rob_id_i[s] = tag[RW-1:0];
    endtask

    task automatic cmt(input int s, input int rd, input int tag);
        c_valid_i[s]  = 1'b1;
        c_wen_i[s]    = 1'b1;
        c_rd_i[s]     = rd[4:0];
        c_rob_id_i[s] = tag[RW-1:0];
    endtask

    task automatic src(input int s, input int o, input int rd);
        r_rs_i[s][o] = rd[4:0];
    endtask

    // Lanes: 0=slot0/op0, 1=slot0/op1, 2=slot1/op0, 3=slot1/op1.
    task automatic exp_full(input string nm, input logic [3:0] b, input int t0, input int t1,
                            input int t2, input int t3, input int cnt, input logic rdy);
        exp_t e;
        e.chk_src = 1'b1;
        e.busy    = b;
        e.tag[0]  = t0[RW-1:0];
        e.tag[1]  = t1[RW-1:0];
        e.tag[2]  = t2[RW-1:0];
        e.tag[3]  = t3[RW-1:0];
        e.cnt     = cnt[5:0];
        e.rdy     = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        obs_req = 1'b1;
    endtask

    task automatic exp_cr(input string nm, input int cnt, input logic rdy);
        exp_t e;
        e.chk_src = 1'b0;
        e.busy    = '0;
        e.tag     = '0;
        e.cnt     = cnt[5:0];
        e.rdy     = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        obs_req = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        obs_req = 1'b0;
        clr_in();
    endtask

    // Monitor: whenever stimulus flags an observation, pop and compare mid-cycle.
    always @(negedge clk) begin
        if (obs_req) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL monitor: observation requested with empty expectation queue");
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if (r_ready_o !== e.rdy) begin
                    n_fail++;
                    $display("FAIL %s ready: got %0b want %0b", nm, r_ready_o, e.rdy);
                end
                n_tests++;
                if (busy_cnt_o !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s busy_cnt: got %0d want %0d", nm, busy_cnt_o, e.cnt);
                end
                if (e.chk_src) begin
                    for (int s = 0; s < 2; s++) begin
                        for (int o = 0; o < 2; o++) begin
                            n_tests++;
                            if (r_src_busy_o[s][o] !== e.busy[s*2+o] ||
                                r_src_tag_o[s][o] !== e.tag[s*2+o]) begin
                                n_fail++;
                                $display("FAIL %s src[%0d][%0d]: got busy=%0b tag=%0d want busy=%0b tag=%0d",
                                         nm, s, o, r_src_busy_o[s][o], r_src_tag_o[s][o],
                                         e.busy[s*2+o], e.tag[s*2+o]);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        src(0, 0, 5); src(0, 1, 7); src(1, 0, 9); src(1, 1, 12);
        exp_full("reset", 4'b0000, 0, 0, 0, 0, 0, 1'b1); tick();

        // Simple rename then lookup
        ren(0, 5, 3); exp_cr("t1_ren", 0, 1'b1); tick();
        src(0, 0, 5); exp_full("t1_look", 4'b0001, 3, 0, 0, 0, 1, 1'b1); tick();

        // Intra-packet bypass to slot1 only
        ren(0, 7, 4); src(0, 0, 7); src(1, 0, 7); src(1, 1, 5);
        exp_full("t2_bypass", 4'b1100, 0, 0, 4, 3, 1, 1'b1); tick();
        src(0, 0, 7); exp_full("t2_after", 4'b0001, 4, 0, 0, 0, 2, 1'b1); tick();
        // Unmasked slot0 must neither bypass nor write
        r_valid_i = 1'b1; r_wen_i[0] = 1'b1; r_rd_i[0] = 5'd8; r_rob_id_i[0] = 5'd9;
        src(1, 0, 8);
        exp_full("t2_nomask", 4'b0000, 0, 0, 0, 0, 2, 1'b1); tick();
        src(0, 0, 8); exp_full("t2_nomask_after", 4'b0000, 0, 0, 0, 0, 2, 1'b1); tick();

        // Stale commit ignored, matching commit clears (write-first lookup)
        ren(0, 9, 2); tick();
        ren(0, 9, 6); tick();
        cmt(0, 9, 2); src(0, 0, 9);
        exp_full("t3_stale_cmt", 4'b0001, 6, 0, 0, 0, 3, 1'b1); tick();
        cmt(1, 9, 6); src(0, 0, 9);
        exp_full("t3_cmt_same", 4'b0000, 0, 0, 0, 0, 3, 1'b1); tick();
        src(0, 0, 9); exp_full("t3_cleared", 4'b0000, 0, 0, 0, 0, 2, 1'b1); tick();
        // Both slots same rd: slot1 tag wins
        ren(0, 10, 11); ren(1, 10, 12); tick();
        src(1, 1, 10); exp_full("t3_dual_rd", 4'b1000, 0, 0, 0, 12, 3, 1'b1); tick();

        // Register 0 never busy
        ren(0, 0, 5); src(1, 0, 0);
        exp_full("t4_rd0_byp", 4'b0000, 0, 0, 0, 0, 3, 1'b1); tick();
        src(0, 0, 0); exp_full("t4_rd0_after", 4'b0000, 0, 0, 0, 0, 3, 1'b1); tick();

        // Same-cycle set and clear of one register: set wins
        ren(0, 12, 1); tick();
        ren(0, 12, 8); cmt(0, 12, 1); tick();
        src(0, 0, 12); exp_full("t5_set_wins", 4'b0001, 8, 0, 0, 0, 4, 1'b1); tick();

        // Fill to 10 busy, then flush
        ren(0, 13, 1); ren(1, 14, 2); tick();
        ren(0, 15, 3); ren(1, 16, 4); tick();
        ren(0, 17, 5); ren(1, 18, 6); tick();
        src(0, 0, 18); exp_full("t6_pre", 4'b0001, 6, 0, 0, 0, 10, 1'b1); tick();
        flush_i = 1'b1; ren(0, 20, 7); cmt(0, 5, 3);
        exp_cr("t6_flush_cyc", 10, 1'b0); tick();
        ren(0, 21, 8); exp_cr("t6_flush_st", 10, 1'b0); tick();
        src(0, 0, 5); src(0, 1, 7); src(1, 0, 20); src(1, 1, 21);
        exp_full("t6_cleared", 4'b0000, 0, 0, 0, 0, 0, 1'b1); tick();

        // Flush held during FLUSH extends it by one cycle
        ren(0, 3, 7); tick();
        flush_i = 1'b1; exp_cr("t7_fl0", 1, 1'b0); tick();
        flush_i = 1'b1; exp_cr("t7_fl1", 1, 1'b0); tick();
        exp_cr("t7_fl2", 0, 1'b0); tick();
        src(0, 0, 3); exp_full("t7_done", 4'b0000, 0, 0, 0, 0, 0, 1'b1); tick();

        // Reset aborts an accepted packet
        ren(0, 4, 2); rst = 1'b1; tick(); rst = 1'b0;
        src(0, 0, 4); exp_full("t8_rst_pkt", 4'b0000, 0, 0, 0, 0, 0, 1'b1); tick();

        // Reset during a flush returns straight to RUN with an empty table
        ren(0, 6, 1); tick();
        flush_i = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
        src(0, 0, 6); exp_full("t8_rst_flush", 4'b0000, 0, 0, 0, 0, 0, 1'b1); tick();

        tick();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
